acs_serial_unit: RTL and testbench

//  Time-multiplexed add-compare-select engine for the hard-decision Viterbi decoder.

---
 rtl/viterbi_pkg.sv | 28 ++
 rtl/acs_butterfly_cell.sv | 27 ++
 rtl/expected_bits.sv | 16 +
 rtl/acs_serial_unit.sv | 129 ++++++++++++
 tb/tb_acs_serial_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, types and helpers for the hard-decision Viterbi decoder blocks.
// Generators use direct octal: tap i of the polynomial multiplies register bit i (bit 0 = newest).
package viterbi_pkg;

    localparam int K    = 5;
    localparam int M    = K - 1;
    localparam int S    = 1 << M;
    localparam int PM_W = 8;

    localparam logic [K-1:0] G0_OCT = 5'o23;
    localparam logic [K-1:0] G1_OCT = 5'o35;

    typedef logic [M-1:0]    state_t;
    typedef logic [PM_W-1:0] pm_t;
    typedef logic [1:0]      sym_t;

    localparam pm_t INIT_PM = pm_t'(1 << (PM_W - 2));

    function automatic logic [1:0] popcount2(input sym_t v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    // Metric every state starts from at reset or on a frame start.
    function automatic pm_t init_metric(input state_t s);
        return (s == '0) ? pm_t'(0) : INIT_PM;
    endfunction

endpackage

// File: rtl/acs_butterfly_cell.sv
// Combinational add-compare-select for one next state: two normalised candidates,
// pick the smaller (ties go to predecessor 0), saturate the winner to all-ones.
module acs_butterfly_cell
    import viterbi_pkg::*;
(
    input  pm_t        pm0,
    input  pm_t        pm1,
    input  pm_t        norm,
    input  sym_t       sym,
    input  sym_t       exp0,
    input  sym_t       exp1,
    output pm_t        pm_new,
    output logic       dec
);

    logic [PM_W:0] cand0;
    logic [PM_W:0] cand1;
    logic [PM_W:0] best;

    // One guard bit lets the sum overflow the metric width so it can be clamped instead of wrapping.
    assign cand0  = {1'b0, pm0 - norm} + {{(PM_W-1){1'b0}}, popcount2(sym ^ exp0)};
    assign cand1  = {1'b0, pm1 - norm} + {{(PM_W-1){1'b0}}, popcount2(sym ^ exp1)};
    assign dec    = (cand1 < cand0);
    assign best   = dec ? cand1 : cand0;
    assign pm_new = best[PM_W] ? '1 : best[PM_W-1:0];

endmodule

// File: rtl/expected_bits.sv
// Encoder output (branch label) for leaving state prev with input bit_in.
// exp_bits[0] is the G0 output, exp_bits[1] the G1 output.
module expected_bits
    import viterbi_pkg::*;
(
    input  state_t     prev,
    input  logic       bit_in,
    output sym_t       exp_bits
);

    logic [K-1:0] window;

    assign window   = {prev, bit_in};
    assign exp_bits = {^(window & G1_OCT), ^(window & G0_OCT)};

endmodule

// File: rtl/acs_serial_unit.sv
// Time-multiplexed ACS engine: one trellis step per accepted symbol, one state per RUN cycle,
// double-buffered path metrics, survivor word and best state handed to traceback in DONE.
module acs_serial_unit
    import viterbi_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sym_valid,
    output logic         sym_ready,
    input  sym_t         sym,
    input  logic         frame_start,
    output logic         surv_valid,
    input  logic         surv_ready,
    output logic [S-1:0] surv_word,
    output state_t       best_state
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t   state;
    fsm_t   state_nxt;
    pm_t    pm_bank [2][S];
    logic   bank_sel;
    pm_t    norm;
    state_t cnt;
    sym_t   sym_q;
    logic   frame_q;
    pm_t    run_min;

    state_t p0;
    state_t p1;
    logic   in_bit;
    pm_t    pm0;
    pm_t    pm1;
    pm_t    norm_eff;
    sym_t   exp0;
    sym_t   exp1;
    pm_t    pm_new;
    logic   dec;
    logic   last;

    assign p0       = {1'b0, cnt[M-1:1]};
    assign p1       = {1'b1, cnt[M-1:1]};
    assign in_bit   = cnt[0];
    assign last     = (cnt == state_t'(S - 1));

    // A frame start bypasses the stored banks entirely and restarts from the initial metrics.
    assign pm0      = frame_q ? init_metric(p0) : pm_bank[bank_sel][p0];
    assign pm1      = frame_q ? init_metric(p1) : pm_bank[bank_sel][p1];
    assign norm_eff = frame_q ? '0 : norm;

    expected_bits u_exp0 (.prev(p0), .bit_in(in_bit), .exp_bits(exp0));
    expected_bits u_exp1 (.prev(p1), .bit_in(in_bit), .exp_bits(exp1));

    acs_butterfly_cell u_acs (
        .pm0    (pm0),
        .pm1    (pm1),
        .norm   (norm_eff),
        .sym    (sym_q),
        .exp0   (exp0),
        .exp1   (exp1),
        .pm_new (pm_new),
        .dec    (dec)
    );

    assign sym_ready  = rst_n && (state == IDLE);
    assign surv_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next-state is assigned its default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sym_valid)  state_nxt = RUN;
            RUN:     if (last)       state_nxt = DONE;
            DONE:    if (surv_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // NOTE: the metric banks are reset explicitly because an aborted step must leave defined metrics behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                pm_bank[0][i] <= init_metric(state_t'(i));
                pm_bank[1][i] <= init_metric(state_t'(i));
            end
            bank_sel   <= 1'b0;
            norm       <= '0;
            cnt        <= '0;
            sym_q      <= '0;
            frame_q    <= 1'b0;
            run_min    <= '0;
            surv_word  <= '0;
            best_state <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sym_valid) begin
                        sym_q   <= sym;
                        frame_q <= frame_start;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    pm_bank[!bank_sel][cnt] <= pm_new;
                    surv_word[cnt]          <= dec;
                    if (cnt == '0 || pm_new < run_min) begin
                        run_min    <= pm_new;
                        best_state <= cnt;
                    end
                    cnt <= cnt + state_t'(1);
                end
                DONE: begin
                    if (surv_ready) begin
                        bank_sel <= !bank_sel;
                        norm     <= run_min;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acs_serial_unit.sv
// Scoreboard bench for acs_serial_unit: a trellis-level reference model predicts each step's
// survivor word and best state; a monitor compares whenever the DUT presents a survivor word.
module tb_acs_serial_unit;
    import viterbi_pkg::*;

    typedef struct {
        logic [S-1:0] word;
        logic [M-1:0] best;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sym_valid;
    logic         sym_ready;
    logic [1:0]   sym_in;
    logic         frame_start;
    logic         surv_valid;
    logic         surv_ready;
    logic [S-1:0] surv_word;
    logic [M-1:0] best_state;

    int   errors = 0;
    int   checks = 0;
    int   mode   = 1;      // surv_ready policy: 0 low, 1 high, 2 random
    exp_t sb_q[$];
    int   pm_m[S];
    int   norm_m;

    acs_serial_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym         (sym_in),
        .frame_start (frame_start),
        .surv_valid  (surv_valid),
        .surv_ready  (surv_ready),
        .surv_word   (surv_word),
        .best_state  (best_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoder output for a transition: window = (prev state << 1) | input, parity of window & generator.
    function automatic logic [1:0] enc_out(input int p, input int b);
        logic [4:0] r;
        logic [1:0] e;
        r    = 5'((p << 1) | b);
        e[0] = ($countones(r & 5'o23) % 2) == 1;
        e[1] = ($countones(r & 5'o35) % 2) == 1;
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < S; i++) pm_m[i] = (i == 0) ? 0 : int'(INIT_PM);
        norm_m = 0;
    endfunction

    function automatic void model_step(input logic [1:0] s, input logic fs);
        int   cur[S];
        int   nxt[S];
        int   nrm;
        int   mn;
        exp_t e;
        mn     = 1 << 30;
        nrm    = fs ? 0 : norm_m;
        e.word = '0;
        e.best = '0;
        for (int i = 0; i < S; i++) cur[i] = fs ? ((i == 0) ? 0 : int'(INIT_PM)) : pm_m[i];
        for (int ns = 0; ns < S; ns++) begin
            int p0, p1, b, c0, c1, v;
            p0 = ns >> 1;
            p1 = p0 + S / 2;
            b  = ns & 1;
            c0 = cur[p0] - nrm + $countones(s ^ enc_out(p0, b));
            c1 = cur[p1] - nrm + $countones(s ^ enc_out(p1, b));
            if (c1 < c0) begin
                e.word[ns] = 1'b1;
                v = c1;
            end else begin
                v = c0;
            end
            if (v > (1 << PM_W) - 1) v = (1 << PM_W) - 1;
            nxt[ns] = v;
            if (v < mn) begin
                mn     = v;
                e.best = 4'(ns);
            end
        end
        pm_m   = nxt;
        norm_m = mn;
        sb_q.push_back(e);
    endfunction

    // Single driver of surv_ready; changes land between the active edge and the sampling edge.
    initial begin
        surv_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       surv_ready = 1'b0;
                1:       surv_ready = 1'b1;
                default: surv_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && surv_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("surv_word", 32'(surv_word), 32'(sb_q[0].word));
                check("best_state", 32'(best_state), 32'(sb_q[0].best));
                if (surv_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic fs, input bit expect_out);
        int w;
        w = 0;
        while (sym_ready !== 1'b1 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (sym_ready !== 1'b1) check("send_timeout", 0, 1);
        sym_valid   = 1'b1;
        sym_in      = s;
        frame_start = fs;
        if (expect_out) model_step(s, fs);
        @(posedge clk);
        #1;
        sym_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Counts cycles from acceptance to surv_valid; returns 999 on timeout.
    task automatic wait_valid(output int lat);
        lat = 999;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (surv_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", sb_q.size(), 0);
    endtask

    task automatic run_message(input int flip_idx);
        logic [11:0] msg;
        logic [1:0]  s;
        int          st;
        msg = 12'($urandom);
        st  = 0;
        for (int i = 0; i < 12; i++) begin
            s  = enc_out(st, int'(msg[i]));
            if (i == flip_idx) s[i % 2] = ~s[i % 2];
            st = ((st << 1) | int'(msg[i])) & (S - 1);
            send(s, (i == 0), 1'b1);
        end
        drain();
    endtask

    initial begin
        int lat;
        #60000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n       = 1'b0;
        sym_valid   = 1'b0;
        sym_in      = 2'b00;
        frame_start = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_sym_ready", sym_ready, 0);
        check("reset_surv_valid", surv_valid, 0);
        rst_n = 1'b1;
        #1;
        check("post_reset_sym_ready", sym_ready, 1);
        check("post_reset_surv_word", 32'(surv_word), 0);
        check("post_reset_best_state", 32'(best_state), 0);
        @(posedge clk);
        #1;

        // Frame start with an all-zero symbol, then with 11.
        send(2'b00, 1'b1, 1'b1);
        wait_valid(lat);
        check("latency_sym00", lat, S);
        check("best_sym00", 32'(best_state), 0);
        drain();
        send(2'b11, 1'b1, 1'b1);
        wait_valid(lat);
        check("latency_sym11", lat, S);
        check("best_sym11", 32'(best_state), 1);
        drain();

        // Error-free encoded message, then the same kind of stream with one flipped bit.
        run_message(-1);
        run_message(5);

        // Downstream stall while a stray symbol is offered.
        mode = 0;
        send(2'($urandom), 1'b0, 1'b1);
        wait_valid(lat);
        check("stall_reached_done", 32'(surv_valid), 1);
        for (int i = 0; i < 10; i++) begin
            sym_valid = (i == 3);
            sym_in    = 2'($urandom);
            @(posedge clk);
            #1;
            check("stall_sym_ready", sym_ready, 0);
            check("stall_surv_valid", surv_valid, 1);
        end
        sym_valid = 1'b0;
        mode = 1;
        drain();
        repeat (S + 4) @(posedge clk);
        #1;
        check("stray_symbol_not_consumed", surv_valid, 0);

        // Reset in the middle of RUN aborts the step.
        send(2'b10, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_surv_valid", surv_valid, 0);
        check("abort_sym_ready", sym_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < S + 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_valid", surv_valid, 0);
        end
        send(2'b00, 1'b0, 1'b1);
        wait_valid(lat);
        check("abort_latency", lat, S);
        check("abort_best", 32'(best_state), 0);
        drain();

        // Random symbols, occasional frame starts and random downstream back-pressure.
        mode = 2;
        for (int i = 0; i < 200; i++) begin
            send(2'($urandom), ($urandom_range(0, 39) == 0), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        mode = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
